// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Brief    : Shared types and default constants for the program-counter generator.
// Revision : 1.0
// ============================================================================
package pc_gen_pkg;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam int unsigned DEFAULT_INSTR_BYTES  = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_if
// Brief    : Redirect/halt inputs and fetch-request outputs of the PC generator.
// Revision : 1.0
// ============================================================================
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) ();

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            halt_req;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            halted;
    logic            misalign_err;
    logic [XLEN-1:0] trap_epc;

    // The PC generator issues fetch requests, so it is the master side.
    modport master (
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        input  fetch_ready,
        output fetch_valid,
        output fetch_pc,
        output halted,
        output misalign_err,
        output trap_epc
    );

    modport slave (
        output redirect_valid,
        output redirect_target,
        output halt_req,
        output fetch_ready,
        input  fetch_valid,
        input  fetch_pc,
        input  halted,
        input  misalign_err,
        input  trap_epc
    );

endinterface : pc_gen_if
`default_nettype wire

// File: rtl/pc_gen_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Brief    : Next-PC mux (redirect / trap / increment / hold) with alignment
//            check. Macro PC_MISALIGN_TRAP_EN selects trap vs force-align.
// Revision : 1.0
// ============================================================================
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN        = DEFAULT_XLEN,
    parameter int unsigned     INSTR_BYTES = DEFAULT_INSTR_BYTES,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] pc_q_i,
    output logic [XLEN-1:0] pc_d_o,
    output logic            trap_o
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    logic            w_misaligned;
    logic [XLEN-1:0] w_target_aligned;

    assign w_misaligned     = |(redirect_target_i & ALIGN_MASK);
    // For an aligned target this is the target itself.
    assign w_target_aligned = redirect_target_i & ~ALIGN_MASK;
    assign trap_o           = TRAP_EN && redirect_valid_i && w_misaligned;

    always_comb begin
        pc_d_o = pc_q_i;
        if (redirect_valid_i) begin
            pc_d_o = trap_o ? TRAP_VECTOR : w_target_aligned;
        end else if (advance_i) begin
            pc_d_o = pc_q_i + PC_STEP;
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Program-counter generator with valid/ready fetch, redirect, halt
//            and misaligned-target handling (trap when PC_MISALIGN_TRAP_EN).
// Revision : 1.0
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_gen_if.master  bus
);

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] trap_epc_q;
    logic [XLEN-1:0] trap_epc_d;
    logic            fetch_valid_q;
    logic            fetch_valid_d;
    logic            halted_q;
    logic            halted_d;
    logic            misalign_err_q;
    logic            misalign_err_d;
    logic            w_accept;
    logic            w_trap;

    assign w_accept = fetch_valid_q & bus.fetch_ready;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .redirect_valid_i  (bus.redirect_valid),
        .redirect_target_i (bus.redirect_target),
        .advance_i         (w_accept),
        .pc_q_i            (fetch_pc_q),
        .pc_d_o            (fetch_pc_d),
        .trap_o            (w_trap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect replaces the pending offer, so it blocks RUN/HALT transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = bus.halt_req ? ST_HALT : ST_RUN;
            ST_RUN: begin
                if (!bus.redirect_valid && bus.halt_req &&
                    (bus.fetch_ready || !fetch_valid_q)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!bus.redirect_valid && !bus.halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Outputs decode the next state so they leave the flops already aligned.
    always_comb begin
        fetch_valid_d  = (state_d == ST_RUN);
        halted_d       = (state_d == ST_HALT);
        misalign_err_d = w_trap;
        trap_epc_d     = w_trap ? bus.redirect_target : trap_epc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q     <= RESET_VECTOR;
            fetch_valid_q  <= 1'b0;
            halted_q       <= 1'b0;
            misalign_err_q <= 1'b0;
            trap_epc_q     <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            fetch_valid_q  <= fetch_valid_d;
            halted_q       <= halted_d;
            misalign_err_q <= misalign_err_d;
            trap_epc_q     <= trap_epc_d;
        end
    end

    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.fetch_pc     = fetch_pc_q;
    assign bus.halted       = halted_q;
    assign bus.misalign_err = misalign_err_q;
    assign bus.trap_epc     = trap_epc_q;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen: directed scenarios plus random
//            stimulus against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] IB = 32'd4;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode flags plus the architectural PC.
    logic        m_boot;
    logic        m_run;
    logic        m_halt;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_epc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot <= 1'b1;
            m_run  <= 1'b0;
            m_halt <= 1'b0;
            m_pc   <= RV;
            m_err  <= 1'b0;
            m_epc  <= 32'h0;
        end else begin
            if (bus.redirect_valid) begin
                if ((bus.redirect_target % IB) != 0)
                    m_pc <= TRAP ? TV : (bus.redirect_target - (bus.redirect_target % IB));
                else
                    m_pc <= bus.redirect_target;
            end else if (m_run && bus.fetch_ready) begin
                m_pc <= m_pc + IB;
            end
            m_err <= TRAP && bus.redirect_valid && ((bus.redirect_target % IB) != 0);
            if (TRAP && bus.redirect_valid && ((bus.redirect_target % IB) != 0))
                m_epc <= bus.redirect_target;
            if (m_boot) begin
                m_boot <= 1'b0;
                m_run  <= !bus.halt_req;
                m_halt <= bus.halt_req;
            end else if (!bus.redirect_valid) begin
                if (m_halt && !bus.halt_req) begin
                    m_run  <= 1'b1;
                    m_halt <= 1'b0;
                end else if (m_run && bus.halt_req && bus.fetch_ready) begin
                    m_run  <= 1'b0;
                    m_halt <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        chk("model fetch_valid", {31'h0, bus.fetch_valid}, {31'h0, m_run});
        chk("model fetch_pc", bus.fetch_pc, m_pc);
        chk("model halted", {31'h0, bus.halted}, {31'h0, m_halt});
        chk("model misalign_err", {31'h0, bus.misalign_err}, {31'h0, m_err});
        chk("model trap_epc", bus.trap_epc, m_epc);
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = tgt;
        step();
        bus.redirect_valid  = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] exp_err;
    logic [31:0] exp_epc;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt_req        = 1'b0;
        bus.fetch_ready     = 1'b0;
        step();
        step();
        chk("reset fetch_pc", bus.fetch_pc, 32'h0);
        chk("reset fetch_valid", {31'h0, bus.fetch_valid}, 32'h0);
        chk("reset halted", {31'h0, bus.halted}, 32'h0);
        chk("reset trap_epc", bus.trap_epc, 32'h0);

        rst_n = 1'b1;
        #1;
        chk("boot no valid", {31'h0, bus.fetch_valid}, 32'h0);
        step();
        chk("first valid", {31'h0, bus.fetch_valid}, 32'h1);
        chk("first pc", bus.fetch_pc, 32'h0);

        // Streaming then stall.
        bus.fetch_ready = 1'b1;
        step(); chk("stream pc 4", bus.fetch_pc, 32'h4);
        step(); chk("stream pc 8", bus.fetch_pc, 32'h8);
        step(); chk("stream pc C", bus.fetch_pc, 32'hC);
        bus.fetch_ready = 1'b0;
        step(); chk("stall pc", bus.fetch_pc, 32'hC);
        step(); chk("stall pc 2", bus.fetch_pc, 32'hC);
        chk("stall valid", {31'h0, bus.fetch_valid}, 32'h1);

        // Redirect wins over a simultaneous accept.
        redirect(32'h8);
        chk("redir pc 8", bus.fetch_pc, 32'h8);
        bus.fetch_ready = 1'b1;
        redirect(32'h8000_0000);
        chk("redir over accept", bus.fetch_pc, 32'h8000_0000);

        // Wrap-around.
        bus.fetch_ready = 1'b0;
        redirect(32'hFFFF_FFFC);
        bus.fetch_ready = 1'b1;
        step();
        chk("wrap pc", bus.fetch_pc, 32'h0);
        chk("wrap no err", {31'h0, bus.misalign_err}, 32'h0);

        // Halt waits for the accept, then resumes.
        bus.fetch_ready = 1'b0;
        redirect(32'h20);
        bus.halt_req = 1'b1;
        step();
        chk("halt pending pc", bus.fetch_pc, 32'h20);
        chk("halt pending halted", {31'h0, bus.halted}, 32'h0);
        bus.fetch_ready = 1'b1;
        step();
        chk("halt entered pc", bus.fetch_pc, 32'h24);
        chk("halt entered halted", {31'h0, bus.halted}, 32'h1);
        chk("halt no valid", {31'h0, bus.fetch_valid}, 32'h0);
        bus.fetch_ready = 1'b0;
        bus.halt_req = 1'b0;
        step();
        chk("resume valid", {31'h0, bus.fetch_valid}, 32'h1);
        chk("resume pc", bus.fetch_pc, 32'h24);

        // Misaligned redirect.
        exp_pc  = TRAP ? 32'h0000_0100 : 32'h0000_1000;
        exp_err = TRAP ? 32'h1 : 32'h0;
        exp_epc = TRAP ? 32'h0000_1002 : 32'h0;
        redirect(32'h0000_1002);
        chk("misalign pc", bus.fetch_pc, exp_pc);
        chk("misalign err", {31'h0, bus.misalign_err}, exp_err);
        chk("misalign epc", bus.trap_epc, exp_epc);
        step();
        chk("misalign err pulse end", {31'h0, bus.misalign_err}, 32'h0);

        // Asynchronous reset in the middle of an offer.
        redirect(32'h10);
        chk("pre-reset pc", bus.fetch_pc, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset pc", bus.fetch_pc, 32'h0);
        chk("async reset valid", {31'h0, bus.fetch_valid}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Random traffic checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.fetch_ready    = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) bus.redirect_target = $urandom;
            else bus.redirect_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) bus.halt_req = ~bus.halt_req;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator; next generation of the single-cycle PC register. Holds the fetch address, presents it to instruction fetch over a valid/ready handshake, and advances by one instruction on each accepted fetch. Also supports stall via backpressure, branch/jump redirect, halt/resume and misaligned-target detection. Sits between the branch/jump resolution logic and the instruction-memory interface.

## Interface
- XLEN, 32: address width in bits (≥ 8).
- RESET_VECTOR, 32'h0000_0000: fetch_pc value while reset is asserted and on the first fetch after reset.
- TRAP_VECTOR, 32'h0000_0100: target taken on a misaligned redirect (only with the trap feature).
- INSTR_BYTES, 4: sequential increment, power of two; alignment granule.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  new fetch address.
- halt_req  in  1  level; request to stop issuing fetches.
- fetch_ready  in  1  fetch consumer accepts fetch_pc this cycle.
- fetch_valid  out  1  fetch_pc is a valid fetch request.
- fetch_pc  out  XLEN  current fetch address (registered).
- halted  out  1  block is in HALT.
- misalign_err  out  1  one-cycle pulse: the last redirect target was misaligned.
- trap_epc  out  XLEN  offending redirect_target captured on misalign_err.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: fetch_valid=0. Next edge goes to HALT if halt_req=1, else to RUN. fetch_pc is unchanged unless a redirect occurs.
- RUN: fetch_valid=1. When the handshake completes (fetch_valid & fetch_ready), fetch_pc <= fetch_pc + INSTR_BYTES. Otherwise fetch_pc holds, which is a stall.
- Handshake rule: once fetch_valid=1, fetch_pc and fetch_valid stay stable until accepted. The only exception is a redirect, which legally replaces the offer.
- Halt: in RUN with halt_req=1, the block enters HALT at the edge where (fetch_ready=1 or no offer is pending). If a fetch is accepted on that same edge, fetch_pc still advances. While halt_req=1 and the offer is unaccepted, the block stays in RUN.
- HALT: fetch_valid=0, halted=1, fetch_pc holds. When halt_req=0, the next edge returns to RUN.
- Redirect priority: reset > redirect > sequential advance > hold.
  - A redirect in any state loads fetch_pc <= target (or the trap value, see Configuration) at the next edge.
  - A redirect overrides a simultaneous accept; no increment is applied.
  - A redirect does not change state. Exception: a redirect in BOOT goes to RUN, unless halt_req=1, in which case it goes to HALT.
- Misaligned redirect means redirect_target mod INSTR_BYTES != 0. On the next edge: misalign_err=1 for exactly one cycle, and trap_epc <= redirect_target.
- Arithmetic: the increment is modulo 2^XLEN. (2^XLEN − INSTR_BYTES) wraps to 0, and no flag is raised.

## Timing
- Reset values: fetch_pc=RESET_VECTOR, fetch_valid=0, halted=0, misalign_err=0, trap_epc=0, state=BOOT.
- Reset is asynchronous assert and applies immediately, including mid-handshake; any pending offer is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- First fetch_valid=1 appears on the first edge after rst_n deasserts, plus one cycle for BOOT.
- Redirect latency is 1 cycle: the target appears on fetch_pc with fetch_valid=1 on the edge after redirect_valid is sampled (state RUN).
- Throughput is one fetch per cycle with fetch_ready held at 1.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A misaligned redirect loads fetch_pc <= TRAP_VECTOR.
  - misalign_err and trap_epc behave as described above.
- PC_MISALIGN_TRAP_EN undefined:
  - A misaligned target is force-aligned by clearing its low log2(INSTR_BYTES) bits.
  - misalign_err is tied to 0 and trap_epc to 0; there is no trap state.

## Structure
- Shared package holds:
  - the state enum (BOOT/RUN/HALT), 2 bits;
  - the default XLEN;
  - the INSTR_BYTES constant;
  - the default RESET_VECTOR and TRAP_VECTOR.
- One sub-module, pc_next_sel: combinational next-PC mux (redirect / trap / increment / hold) plus the alignment check. The top-level module keeps the state register and output flops.

## Test plan
- Reset behaviour:
  - Stimulus: assert rst_n=0 mid-offer with fetch_pc=0x0000_0010.
  - Required: fetch_pc=0x0000_0000 and fetch_valid=0 without waiting for a clock edge.
  - After release: BOOT for one cycle, then fetch_valid=1.
- Streaming and stall:
  - Stimulus: fetch_ready=1 for 3 cycles from 0x0.
  - Required: fetch_pc sequence 0x0, 0x4, 0x8, 0xC.
  - Then fetch_ready=0 for 2 cycles: fetch_pc holds 0xC and fetch_valid stays 1.
- Redirect over accept:
  - Stimulus: at fetch_pc=0x8 with fetch_ready=1, redirect_valid=1, target=0x8000_0000.
  - Required next fetch_pc: 0x8000_0000, not 0xC.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFC, then accept.
  - Required: fetch_pc=0x0000_0000, misalign_err=0.
- Halt/resume:
  - Stimulus: halt_req=1 with fetch_ready=0 at fetch_pc=0x20.
  - Required: stays in RUN holding 0x20; on accept, enters HALT with fetch_pc=0x24 and halted=1.
  - halt_req=0: next cycle fetch_valid=1 at 0x24.
- Misaligned redirect:
  - Stimulus: redirect to 0x0000_1002.
  - With PC_MISALIGN_TRAP_EN: fetch_pc=0x0000_0100, misalign_err pulses for 1 cycle, trap_epc=0x0000_1002.
  - Without the macro: fetch_pc=0x0000_1000 and misalign_err=0.
